// File: rtl/fft_pkg.sv
// Shared FFT constants and the bit-reversal helper used to index the
// reorder buffer.
package fft_pkg;

  localparam int FFT_N     = 64;
  localparam int FFT_LOG2N = 6;
  localparam int FFT_OUT_W = 17;

  // Reverses the low log2n bits of idx; bits at and above log2n come out as 0.
  function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] idx,
                                                  input int log2n);
    logic [FFT_LOG2N-1:0] x;
    logic [FFT_LOG2N-1:0] r;
    x = idx;
    r = '0;
    for (int i = 0; i < FFT_LOG2N; i++) begin
      if (i < log2n) begin
        r = {r[FFT_LOG2N-2:0], x[0]};
        x = x >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port with enable.
// rdata holds its value whenever re is low, so it doubles as the output data register.
module fft_reorder_ram #(
  parameter int AW = 7,
  parameter int DW = 34
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder of bit-reversed FFT frames into natural-order 64-cycle bursts.
// First output bin 2 cycles after the last input sample; no backpressure in either direction.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int W     = FFT_OUT_W,
  parameter int LOG2N = FFT_LOG2N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     din_re,
  input  logic [W-1:0]     din_im,
  input  logic             din_valid,
  output logic [W-1:0]     dout_re,
  output logic [W-1:0]     dout_im,
  output logic             dout_valid,
  output logic [LOG2N-1:0] dout_idx,
  output logic             dout_sof,
  output logic             dout_eof
);

  localparam logic             ST_IDLE = 1'b0;
  localparam logic             ST_READ = 1'b1;
  localparam logic [LOG2N-1:0] LAST    = '1;

  logic [LOG2N-1:0] wr_cnt;
  logic             wb;
  logic             rb;
  logic [1:0]       full;
  logic [1:0]       full_nxt;
  logic             state;
  logic [LOG2N-1:0] rd_addr;
  logic             rd_en;
  logic             wr_done;
  logic             rd_done;
  logic [2*W-1:0]   rdata;

  assign rd_en   = (state == ST_READ);
  assign wr_done = din_valid && (wr_cnt == LAST);
  assign rd_done = rd_en && (rd_addr == LAST);

  // Write and read always target different banks, so set and clear never collide.
  always_comb begin
    full_nxt = full;
    if (wr_done) full_nxt[wb] = 1'b1;
    if (rd_done) full_nxt[rb] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt     <= '0;
      wb         <= 1'b0;
      rb         <= 1'b0;
      full       <= 2'b00;
      state      <= ST_IDLE;
      rd_addr    <= '0;
      dout_valid <= 1'b0;
      dout_idx   <= '0;
      dout_sof   <= 1'b0;
      dout_eof   <= 1'b0;
    end else begin
      full <= full_nxt;
      if (din_valid) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_done) wb <= ~wb;
      end

      case (state)
        ST_IDLE: begin
          if (full[rb]) begin
            state   <= ST_READ;
            rd_addr <= '0;
          end
        end
        default: begin
          rd_addr <= rd_addr + 1'b1;
          if (rd_done) begin
            rb <= ~rb;
            // Other bank already waiting: keep reading with no bubble.
            if (!full[~rb]) state <= ST_IDLE;
          end
        end
      endcase

      dout_valid <= rd_en;
      if (rd_en) begin
        dout_idx <= rd_addr;
        dout_sof <= (rd_addr == '0);
        dout_eof <= (rd_addr == LAST);
      end
    end
  end

  fft_reorder_ram #(
    .AW(LOG2N + 1),
    .DW(2 * W)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (din_valid),
    .waddr({wb, bitrev(wr_cnt, LOG2N)}),
    .wdata({din_re, din_im}),
    .re   (rd_en),
    .raddr({rb, rd_addr}),
    .rdata(rdata)
  );

  assign dout_re = rdata[2*W-1:W];
  assign dout_im = rdata[W-1:0];

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench for fft_bitrev_reorder: driver pushes expected natural-order bins,
// a negedge monitor pops and compares data, index, frame markers and output cycle.
module tb_fft_bitrev_reorder;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [16:0] din_re = '0;
  logic signed [16:0] din_im = '0;
  logic               din_valid = 1'b0;
  logic signed [16:0] dout_re;
  logic signed [16:0] dout_im;
  logic               dout_valid;
  logic [5:0]         dout_idx;
  logic               dout_sof;
  logic               dout_eof;

  typedef struct {
    logic signed [16:0] re;
    logic signed [16:0] im;
    logic [5:0]         idx;
    logic               sof;
    logic               eof;
    int                 cyc;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  fft_bitrev_reorder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din_re    (din_re),
    .din_im    (din_im),
    .din_valid (din_valid),
    .dout_re   (dout_re),
    .dout_im   (dout_im),
    .dout_valid(dout_valid),
    .dout_idx  (dout_idx),
    .dout_sof  (dout_sof),
    .dout_eof  (dout_eof)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rev6(input int k);
    int r;
    r = 0;
    for (int b = 0; b < 6; b++) if (k & (1 << b)) r = r | (1 << (5 - b));
    return r;
  endfunction

  function automatic int bin_re(input int f, input int b, input bit extreme);
    if (extreme && b == 5) return -65536;
    return b + 100 * f;
  endfunction

  function automatic int bin_im(input int f, input int b, input bit extreme);
    if (extreme && b == 5) return 65535;
    return -(b + 100 * f);
  endfunction

  // Monitor: every valid output must match the head of the scoreboard, including its cycle.
  always @(negedge clk) begin
    if (dout_valid === 1'b1) begin
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out: got idx=%0d re=%0d im=%0d at cyc %0d, required no output",
                 dout_idx, dout_re, dout_im, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (dout_re !== e.re || dout_im !== e.im || dout_idx !== e.idx ||
            dout_sof !== e.sof || dout_eof !== e.eof || cyc != e.cyc) begin
          fails++;
          $display("FAIL bin_out: got re=%0d im=%0d idx=%0d sof=%0b eof=%0b cyc=%0d, required re=%0d im=%0d idx=%0d sof=%0b eof=%0b cyc=%0d",
                   dout_re, dout_im, dout_idx, dout_sof, dout_eof, cyc,
                   e.re, e.im, e.idx, e.sof, e.eof, e.cyc);
        end
      end
    end
  end

  // Sends nsamp samples of frame f in bit-reversed order; on completion pushes the first npush bins.
  task automatic send_frame(input int f, input int gap_pct, input int nsamp,
                            input int npush, input bit extreme);
    int e_cyc;
    for (int k = 0; k < nsamp; k++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        din_valid = 1'b0;
        din_re    = 17'($urandom);
        din_im    = 17'($urandom);
        @(posedge clk); #1;
      end
      din_re    = 17'(bin_re(f, rev6(k), extreme));
      din_im    = 17'(bin_im(f, rev6(k), extreme));
      din_valid = 1'b1;
      @(posedge clk); #1;
      din_valid = 1'b0;
    end
    if (nsamp == 64) begin
      e_cyc = cyc;
      for (int b = 0; b < npush; b++) begin
        exp_t e;
        e.re  = 17'(bin_re(f, b, extreme));
        e.im  = 17'(bin_im(f, b, extreme));
        e.idx = 6'(b);
        e.sof = (b == 0);
        e.eof = (b == 63);
        e.cyc = e_cyc + 2 + b;
        sbq.push_back(e);
      end
    end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d bins still pending after timeout, required 0", name, sbq.size());
      sbq.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    tests++;
    if (dout_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s: got dout_valid=%0b, required 0", name, dout_valid);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    tests++;
    if (dout_valid !== 1'b0 || dout_re !== 17'sd0 || dout_im !== 17'sd0 ||
        dout_idx !== 6'd0 || dout_sof !== 1'b0 || dout_eof !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got v=%0b re=%0d im=%0d idx=%0d sof=%0b eof=%0b, required all 0",
               dout_valid, dout_re, dout_im, dout_idx, dout_sof, dout_eof);
    end
    @(posedge clk); #1;

    send_frame(0, 0, 64, 64, 1'b0);
    drain("single");

    for (int f = 1; f <= 3; f++) send_frame(f, 0, 64, 64, 1'b0);
    drain("b2b");

    for (int f = 0; f < 2; f++) send_frame(f, 30, 64, 64, 1'b0);
    drain("gaps");

    send_frame(4, 0, 64, 64, 1'b1);
    drain("extreme");

    send_frame(7, 0, 40, 0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_idle("midframe_rst_valid");
    @(posedge clk); #1;
    send_frame(5, 0, 64, 64, 1'b0);
    drain("after_rst");

    send_frame(6, 0, 64, 10, 1'b0);
    repeat (11) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_idle("read_rst_valid");
    repeat (100) @(posedge clk);
    #1;
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL read_rst_pending: got %0d bins outstanding, required 0", sbq.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
